// File: rtl/fpga_mem_b_port2_arbiter.sv
// Round-robin arbiter and burst sequencer for port s2 of FPGA_Mem_B.
// Two requesters take turns owning the port for whole read or write bursts.
module fpga_mem_b_port2_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_cmd_valid,
    output logic              r0_cmd_ready,
    input  logic              r0_cmd_write,
    input  logic [ADDR_W-1:0] r0_cmd_addr,
    input  logic [LEN_W-1:0]  r0_cmd_len,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r0_wvalid,
    output logic              r0_wready,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,
    input  logic              r1_cmd_valid,
    output logic              r1_cmd_ready,
    input  logic              r1_cmd_write,
    input  logic [ADDR_W-1:0] r1_cmd_addr,
    input  logic [LEN_W-1:0]  r1_cmd_len,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r1_wvalid,
    output logic              r1_wready,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid,
    output logic [ADDR_W-1:0] mem_address2,
    output logic              mem_chipselect2,
    output logic              mem_write2,
    output logic [DATA_W-1:0] mem_writedata2,
    output logic              mem_clken2,
    input  logic [DATA_W-1:0] mem_readdata2,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   last_addr_r;
    logic [LEN_W-1:0]    cnt_r;
    logic                owner_r;
    logic                prio_r;
    logic                r0_rvalid_r;
    logic                r1_rvalid_r;

    logic                grant_s;
    logic                winner_s;
    logic                sel_write_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [LEN_W-1:0]    sel_len_s;
    logic                own_wvalid_s;
    logic                beat_s;

    // Arbitration: a lone requester wins outright, a tie goes to prio_r.
    always_comb begin
        grant_s  = 1'b0;
        winner_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (r0_cmd_valid && r1_cmd_valid) begin
                grant_s  = 1'b1;
                winner_s = prio_r;
            end else if (r0_cmd_valid) begin
                grant_s  = 1'b1;
                winner_s = 1'b0;
            end else if (r1_cmd_valid) begin
                grant_s  = 1'b1;
                winner_s = 1'b1;
            end else begin
                grant_s  = 1'b0;
                winner_s = 1'b0;
            end
        end else begin
            grant_s  = 1'b0;
            winner_s = 1'b0;
        end
    end

    // Command field and write-beat selection for the winner / current owner.
    always_comb begin
        sel_write_s  = r0_cmd_write;
        sel_addr_s   = r0_cmd_addr;
        sel_len_s    = r0_cmd_len;
        own_wvalid_s = r0_wvalid;
        if (winner_s) begin
            sel_write_s = r1_cmd_write;
            sel_addr_s  = r1_cmd_addr;
            sel_len_s   = r1_cmd_len;
        end else begin
            sel_write_s = r0_cmd_write;
            sel_addr_s  = r0_cmd_addr;
            sel_len_s   = r0_cmd_len;
        end
        if (owner_r) begin
            own_wvalid_s = r1_wvalid;
        end else begin
            own_wvalid_s = r0_wvalid;
        end
    end

    // A beat issues every RD cycle, and in WR only when the owner has data.
    always_comb begin
        beat_s = 1'b0;
        case (state_r)
            ST_RD:   beat_s = 1'b1;
            ST_WR:   beat_s = own_wvalid_s;
            default: beat_s = 1'b0;
        endcase
    end

    // Burst sequencer state, pointers and round-robin bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            last_addr_r <= {ADDR_W{1'b0}};
            cnt_r       <= {LEN_W{1'b0}};
            owner_r     <= 1'b0;
            prio_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        addr_r  <= sel_addr_s;
                        cnt_r   <= sel_len_s;
                        owner_r <= winner_s;
                        prio_r  <= ~winner_s;
                        state_r <= sel_write_s ? ST_WR : ST_RD;
                    end
                end
                ST_RD, ST_WR: begin
                    if (beat_s) begin
                        last_addr_r <= addr_r;
                        // Wraps modulo 2^ADDR_W by construction.
                        addr_r      <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (cnt_r == {LEN_W{1'b0}}) begin
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r <= cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Read-valid pipeline tracks the one-cycle RAM read latency.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r0_rvalid_r <= 1'b0;
            r1_rvalid_r <= 1'b0;
        end else begin
            r0_rvalid_r <= (state_r == ST_RD) && !owner_r;
            r1_rvalid_r <= (state_r == ST_RD) &&  owner_r;
        end
    end

    assign r0_cmd_ready    = grant_s && !winner_s;
    assign r1_cmd_ready    = grant_s &&  winner_s;
    assign r0_wready       = (state_r == ST_WR) && !owner_r;
    assign r1_wready       = (state_r == ST_WR) &&  owner_r;
    assign r0_rvalid       = r0_rvalid_r;
    assign r1_rvalid       = r1_rvalid_r;
    assign r0_rdata        = mem_readdata2;
    assign r1_rdata        = mem_readdata2;
    // Outside a burst the port shows the last address it actually used.
    assign mem_address2    = (state_r == ST_IDLE) ? last_addr_r : addr_r;
    assign mem_chipselect2 = beat_s;
    assign mem_write2      = (state_r == ST_WR) && own_wvalid_s;
    assign mem_writedata2  = owner_r ? r1_wdata : r0_wdata;
    assign mem_clken2      = 1'b1;
    assign busy            = (state_r != ST_IDLE);
    assign owner           = owner_r;

endmodule

// File: tb/tb_fpga_mem_b_port2_arbiter.sv
// Directed bench for fpga_mem_b_port2_arbiter with a behavioural port-s2 RAM.
// Unwritten RAM words read back as their own address.
module tb_fpga_mem_b_port2_arbiter;

    logic         clk;
    logic         reset_n;
    logic         r0_cmd_valid, r0_cmd_ready, r0_cmd_write;
    logic [10:0]  r0_cmd_addr;
    logic [7:0]   r0_cmd_len;
    logic [255:0] r0_wdata, r0_rdata;
    logic         r0_wvalid, r0_wready, r0_rvalid;
    logic         r1_cmd_valid, r1_cmd_ready, r1_cmd_write;
    logic [10:0]  r1_cmd_addr;
    logic [7:0]   r1_cmd_len;
    logic [255:0] r1_wdata, r1_rdata;
    logic         r1_wvalid, r1_wready, r1_rvalid;
    logic [10:0]  mem_address2;
    logic         mem_chipselect2, mem_write2, mem_clken2;
    logic [255:0] mem_writedata2, mem_readdata2;
    logic         busy, owner;

    logic [255:0] ram [0:2047];
    logic [2047:0] written;
    logic         ram_clr;

    int checks;
    int errors;

    localparam logic [255:0] D1 = {8{32'hA5A5_0001}};
    localparam logic [255:0] D2 = {8{32'h5A5A_0002}};

    fpga_mem_b_port2_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .r0_cmd_valid(r0_cmd_valid), .r0_cmd_ready(r0_cmd_ready),
        .r0_cmd_write(r0_cmd_write), .r0_cmd_addr(r0_cmd_addr),
        .r0_cmd_len(r0_cmd_len), .r0_wdata(r0_wdata), .r0_wvalid(r0_wvalid),
        .r0_wready(r0_wready), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
        .r1_cmd_valid(r1_cmd_valid), .r1_cmd_ready(r1_cmd_ready),
        .r1_cmd_write(r1_cmd_write), .r1_cmd_addr(r1_cmd_addr),
        .r1_cmd_len(r1_cmd_len), .r1_wdata(r1_wdata), .r1_wvalid(r1_wvalid),
        .r1_wready(r1_wready), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
        .mem_address2(mem_address2), .mem_chipselect2(mem_chipselect2),
        .mem_write2(mem_write2), .mem_writedata2(mem_writedata2),
        .mem_clken2(mem_clken2), .mem_readdata2(mem_readdata2),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port s2 RAM: write on the edge, read data one cycle after the address.
    always @(posedge clk) begin
        if (ram_clr) begin
            written <= '0;
        end else if (mem_chipselect2 && mem_write2) begin
            ram[mem_address2]     <= mem_writedata2;
            written[mem_address2] <= 1'b1;
        end
        if (mem_chipselect2 && !mem_write2) begin
            mem_readdata2 <= written[mem_address2] ? ram[mem_address2] : {245'd0, mem_address2};
        end
    end

    function automatic logic [255:0] w256(input int v);
        return {224'd0, 32'(v)};
    endfunction

    function automatic logic [255:0] ram_word(input int a);
        return written[a] ? ram[a] : w256(a);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rv_cnt;
        int bad;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        ram_clr = 1'b1;
        r0_cmd_valid = 1'b0; r0_cmd_write = 1'b0; r0_cmd_addr = 11'd0; r0_cmd_len = 8'd0;
        r0_wdata = 256'd0; r0_wvalid = 1'b0;
        r1_cmd_valid = 1'b0; r1_cmd_write = 1'b0; r1_cmd_addr = 11'd0; r1_cmd_len = 8'd0;
        r1_wdata = 256'd0; r1_wvalid = 1'b0;
        repeat (3) cyc();
        ram_clr = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_ready", {r0_cmd_ready, r1_cmd_ready}, 2'b00);
        chk("rst_wready", {r0_wready, r1_wready}, 2'b00);
        chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 2'b00);
        chk("rst_strobes", {mem_chipselect2, mem_write2}, 2'b00);
        chk("rst_addr", mem_address2, 11'h000);
        chk("rst_clken", mem_clken2, 1'b1);

        // Single read: r0, 0x010, 4 beats
        cyc();
        reset_n = 1'b1;
        r0_cmd_valid = 1'b1; r0_cmd_write = 1'b0; r0_cmd_addr = 11'h010; r0_cmd_len = 8'd3;
        #1;
        chk("rd1_ready0", r0_cmd_ready, 1'b1);
        chk("rd1_ready1", r1_cmd_ready, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 0) r0_cmd_valid = 1'b0;
            #1;
            chk("rd1_busy", busy, (i <= 3));
            chk("rd1_cs", {mem_chipselect2, mem_write2}, {(i <= 3), 1'b0});
            chk("rd1_addr", mem_address2, (i <= 3) ? 11'(16 + i) : 11'h013);
            chk("rd1_rvalid0", r0_rvalid, (i >= 1 && i <= 4));
            chk("rd1_rvalid1", r1_rvalid, 1'b0);
            if (i >= 1 && i <= 4) chk("rd1_rdata", r0_rdata, w256(16 + i - 1));
        end

        // Gapped write by r1 across the top of memory
        cyc();
        r1_cmd_valid = 1'b1; r1_cmd_write = 1'b1; r1_cmd_addr = 11'h7FF; r1_cmd_len = 8'd1;
        #1;
        chk("wr_ready1", r1_cmd_ready, 1'b1);
        chk("wr_ready0", r0_cmd_ready, 1'b0);
        cyc();
        r1_cmd_valid = 1'b0; r1_wvalid = 1'b1; r1_wdata = D1;
        #1;
        chk("wr_wready", {r0_wready, r1_wready}, 2'b01);
        chk("wr_b0_strobes", {mem_chipselect2, mem_write2}, 2'b11);
        chk("wr_b0_addr", mem_address2, 11'h7FF);
        chk("wr_b0_data", mem_writedata2, D1);
        chk("wr_owner", owner, 1'b1);
        for (int g = 0; g < 3; g++) begin
            cyc();
            r1_wvalid = 1'b0;
            #1;
            chk("wr_gap_strobes", {mem_chipselect2, mem_write2}, 2'b00);
            chk("wr_gap_busy", busy, 1'b1);
            chk("wr_gap_wready", r1_wready, 1'b1);
        end
        cyc();
        r1_wvalid = 1'b1; r1_wdata = D2;
        #1;
        chk("wr_b1_addr_wrap", mem_address2, 11'h000);
        chk("wr_b1_strobes", {mem_chipselect2, mem_write2}, 2'b11);
        chk("wr_b1_data", mem_writedata2, D2);
        cyc();
        r1_wvalid = 1'b0;
        r0_cmd_valid = 1'b1; r0_cmd_write = 1'b0; r0_cmd_addr = 11'h7FF; r0_cmd_len = 8'd1;
        #1;
        chk("wr_done_busy", busy, 1'b0);
        chk("wr_done_strobes", {mem_chipselect2, mem_write2}, 2'b00);
        chk("wr_done_wready", r1_wready, 1'b0);
        chk("rb_ready0", r0_cmd_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) r0_cmd_valid = 1'b0;
            #1;
            chk("rb_addr", mem_address2, (i == 0) ? 11'h7FF : 11'h000);
            chk("rb_cs", mem_chipselect2, (i <= 1));
            chk("rb_rvalid", r0_rvalid, (i == 1 || i == 2));
            if (i == 1) chk("rb_data0", r0_rdata, D1);
            if (i == 2) chk("rb_data1", r0_rdata, D2);
        end

        // Contention right after reset
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        r0_cmd_valid = 1'b1; r0_cmd_write = 1'b0; r0_cmd_addr = 11'h020; r0_cmd_len = 8'd0;
        r1_cmd_valid = 1'b1; r1_cmd_write = 1'b0; r1_cmd_addr = 11'h030; r1_cmd_len = 8'd0;
        #1;
        chk("ct_ready", {r0_cmd_ready, r1_cmd_ready}, 2'b10);
        cyc();
        r0_cmd_valid = 1'b0;
        #1;
        chk("ct_r0_addr", mem_address2, 11'h020);
        chk("ct_r1_held", r1_cmd_ready, 1'b0);
        chk("ct_r0_owner", owner, 1'b0);
        cyc();
        #1;
        chk("ct_r1_ready", r1_cmd_ready, 1'b1);
        chk("ct_r0_rvalid", r0_rvalid, 1'b1);
        chk("ct_r0_rdata", r0_rdata, w256(32'h20));
        cyc();
        r1_cmd_valid = 1'b0;
        #1;
        chk("ct_r1_addr", mem_address2, 11'h030);
        chk("ct_r1_owner", owner, 1'b1);
        cyc();
        #1;
        chk("ct_r1_rvalid", {r0_rvalid, r1_rvalid}, 2'b01);
        chk("ct_r1_rdata", r1_rdata, w256(32'h30));
        r0_cmd_valid = 1'b1;
        r1_cmd_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            if (g > 0) cyc();
            #1;
            chk("alt_ready", {r0_cmd_ready, r1_cmd_ready}, (g % 2 == 0) ? 2'b10 : 2'b01);
            cyc();
            #1;
            chk("alt_owner", owner, (g % 2 == 1));
            chk("alt_busy", busy, 1'b1);
        end
        cyc();
        r1_cmd_valid = 1'b0;

        // Maximum burst: 256 beats from 0x100
        r0_cmd_valid = 1'b1; r0_cmd_write = 1'b0; r0_cmd_addr = 11'h100; r0_cmd_len = 8'd255;
        #1;
        chk("max_ready", r0_cmd_ready, 1'b1);
        rv_cnt = 0;
        bad = 0;
        for (int i = 0; i < 258; i++) begin
            cyc();
            if (i == 0) r0_cmd_valid = 1'b0;
            #1;
            if (r0_rvalid) begin
                rv_cnt++;
                if (r0_rdata !== w256(256 + rv_cnt - 1)) bad++;
            end
            if (i <= 255 && (mem_address2 !== 11'(256 + i) || !busy || !mem_chipselect2)) bad++;
            if (i == 255) chk("max_last_addr", mem_address2, 11'h1FF);
            if (i == 256) chk("max_busy_end", busy, 1'b0);
        end
        chk("max_rvalid_count", rv_cnt, 256);
        chk("max_beat_errors", bad, 0);

        // Reset in the middle of a 10-beat write at 0x200
        cyc();
        r0_cmd_valid = 1'b1; r0_cmd_write = 1'b1; r0_cmd_addr = 11'h200; r0_cmd_len = 8'd9;
        #1;
        chk("rw_ready", r0_cmd_ready, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            r0_cmd_valid = 1'b0;
            r0_wvalid = 1'b1;
            r0_wdata = w256(32'hBEEF00 + k);
            #1;
            chk("rw_beat_cs", {mem_chipselect2, mem_write2}, 2'b11);
        end
        cyc();
        r0_wvalid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rw_prereset_busy", busy, 1'b1);
        cyc();
        #1;
        chk("rw_abort_cs", mem_chipselect2, 1'b0);
        chk("rw_abort_busy", busy, 1'b0);
        chk("rw_abort_wready", r0_wready, 1'b0);
        reset_n = 1'b1;
        r0_cmd_write = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("rw_ram", ram_word(32'h200 + k), (k < 5) ? w256(32'hBEEF00 + k) : w256(32'h200 + k));
        end

        // Hold-off: r1 requests while r0 owns the port
        cyc();
        r0_cmd_valid = 1'b1; r0_cmd_write = 1'b0; r0_cmd_addr = 11'h040; r0_cmd_len = 8'd2;
        #1;
        chk("ho_ready0", r0_cmd_ready, 1'b1);
        cyc();
        r0_cmd_valid = 1'b0;
        r1_cmd_valid = 1'b1; r1_cmd_write = 1'b0; r1_cmd_addr = 11'h050; r1_cmd_len = 8'd0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            #1;
            chk("ho_held", r1_cmd_ready, 1'b0);
            chk("ho_busy", busy, 1'b1);
        end
        cyc();
        #1;
        chk("ho_released", r1_cmd_ready, 1'b1);
        chk("ho_idle", busy, 1'b0);
        cyc();
        r1_cmd_valid = 1'b0;
        #1;
        chk("ho_owner", owner, 1'b1);
        chk("ho_addr", mem_address2, 11'h050);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
